// File: rtl/clock_ui_pkg.sv
// Shared types and helpers for the front-panel time-setting controller.
package clock_ui_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_HOUR,
        ST_SET_MIN,
        ST_SET_SEC,
        ST_COMMIT
    } state_e;

    typedef enum logic [1:0] {
        FLD_NONE = 2'd0,
        FLD_HOUR = 2'd1,
        FLD_MIN  = 2'd2,
        FLD_SEC  = 2'd3
    } field_e;

    localparam logic [4:0] HOUR_MAX   = 5'd23;
    localparam logic [5:0] MINSEC_MAX = 6'd59;

    localparam int KEY_MODE   = 0;
    localparam int KEY_UP     = 1;
    localparam int KEY_DOWN   = 2;
    localparam int KEY_CANCEL = 3;

    // Single up/down step with wrap between 0 and vmax.
    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] vmax,
                                             input logic up);
        if (up) return (v >= vmax) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? vmax : v - 6'd1;
    endfunction

    // COMMIT keeps the seconds field selected so the display does not jump.
    function automatic field_e field_of(input state_e s);
        case (s)
            ST_SET_HOUR: return FLD_HOUR;
            ST_SET_MIN:  return FLD_MIN;
            ST_SET_SEC:  return FLD_SEC;
            ST_COMMIT:   return FLD_SEC;
            default:     return FLD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-FF synchronizer, stability counter, press pulse and held level.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press,
    output logic held
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q, sync_d;
    logic          db_q, db_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only advances while the synchronized sample disagrees with the debounced level.
    always_comb begin
        sync_d  = {sync_q[0], key_n};
        db_d    = db_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync_q[1] != db_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_d    = sync_q[1];
                press_d = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            db_q    <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;
    assign held  = ~db_q;

endmodule

// File: rtl/clock_set_controller.sv
// Front-panel mode machine: edits hour/min/sec, commits with a load pulse, drives blink masks.
module clock_set_controller
    import clock_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int TIMEOUT_CYCLES  = 500000000,
    parameter int BLINK_HALF      = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_n,
    input  logic [4:0] hour_in,
    input  logic [5:0] min_in,
    input  logic [5:0] sec_in,
    output logic       set,
    output logic [1:0] sethms,
    output logic [4:0] hour_out,
    output logic [5:0] min_out,
    output logic [5:0] sec_out,
    output logic       load,
    output logic [2:0] blank_mask
);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(RPT_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);

    logic [3:0] press, held;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key [3:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_n),
        .press (press),
        .held  (held)
    );

    logic unused_held;
    assign unused_held = ^{held[KEY_MODE], held[KEY_CANCEL]};

    state_e        state_q, state_d;
    logic [4:0]    hour_q, hour_d;
    logic [5:0]    min_q, min_d, sec_q, sec_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          set_q, set_d, load_q, load_d;
    field_e        sethms_q, sethms_d;
    logic [2:0]    blank_mask_q, blank_mask_d;

    // Repeat channels: index 0 = up, 1 = down.
    logic [1:0][RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [1:0]         rpt_first_q, rpt_first_d;
    logic [1:0]         step, rk_press, rk_held;
    logic               in_set, up_ev, dn_ev, ud_ok;

    assign in_set   = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN) || (state_q == ST_SET_SEC);
    assign rk_press = {press[KEY_DOWN], press[KEY_UP]};
    assign rk_held  = {held[KEY_DOWN], held[KEY_UP]};

    // A press restarts the channel; first step after REPEAT_DELAY, then every REPEAT_RATE.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rpt_cnt_d[i]   = '0;
            rpt_first_d[i] = 1'b0;
            step[i]        = 1'b0;
            if (in_set && rk_held[i] && !rk_press[i]) begin
                rpt_first_d[i] = rpt_first_q[i];
                rpt_cnt_d[i]   = rpt_cnt_q[i] + 1'b1;
                if (!rpt_first_q[i] && rpt_cnt_q[i] == RW'(REPEAT_DELAY - 1)) begin
                    step[i]        = 1'b1;
                    rpt_cnt_d[i]   = '0;
                    rpt_first_d[i] = 1'b1;
                end else if (rpt_first_q[i] && rpt_cnt_q[i] == RW'(REPEAT_RATE - 1)) begin
                    step[i]      = 1'b1;
                    rpt_cnt_d[i] = '0;
                end
            end
        end
    end

    assign up_ev = press[KEY_UP] | step[0];
    assign dn_ev = press[KEY_DOWN] | step[1];
    assign ud_ok = up_ev ^ dn_ev;

    always_comb begin
        state_d   = state_q;
        hour_d    = hour_q;
        min_d     = min_q;
        sec_d     = sec_q;
        tmo_cnt_d = '0;
        case (state_q)
            ST_RUN: begin
                if (press[KEY_MODE]) begin
                    hour_d  = hour_in;
                    min_d   = min_in;
                    sec_d   = sec_in;
                    state_d = ST_SET_HOUR;
                end
            end
            ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
                if (press[KEY_CANCEL]) begin
                    state_d = ST_RUN;
                end else if (press[KEY_MODE]) begin
                    state_d = (state_q == ST_SET_HOUR) ? ST_SET_MIN :
                              (state_q == ST_SET_MIN)  ? ST_SET_SEC : ST_COMMIT;
                end else if (ud_ok) begin
                    case (state_q)
                        ST_SET_HOUR: hour_d = 5'(wrap_step({1'b0, hour_q}, {1'b0, HOUR_MAX}, up_ev));
                        ST_SET_MIN:  min_d  = wrap_step(min_q, MINSEC_MAX, up_ev);
                        default:     sec_d  = wrap_step(sec_q, MINSEC_MAX, up_ev);
                    endcase
                end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
        set_d        = (state_d != ST_RUN);
        load_d       = (state_d == ST_COMMIT);
        sethms_d     = field_of(state_d);
        blank_mask_d = 3'b000;
        case (sethms_d)
            FLD_HOUR: blank_mask_d[2] = phase_d;
            FLD_MIN:  blank_mask_d[1] = phase_d;
            FLD_SEC:  blank_mask_d[0] = phase_d;
            default:  blank_mask_d    = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            hour_q       <= '0;
            min_q        <= '0;
            sec_q        <= '0;
            tmo_cnt_q    <= '0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
            rpt_cnt_q    <= '0;
            rpt_first_q  <= '0;
            set_q        <= 1'b0;
            load_q       <= 1'b0;
            sethms_q     <= FLD_NONE;
            blank_mask_q <= '0;
        end else begin
            state_q      <= state_d;
            hour_q       <= hour_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            tmo_cnt_q    <= tmo_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            rpt_cnt_q    <= rpt_cnt_d;
            rpt_first_q  <= rpt_first_d;
            set_q        <= set_d;
            load_q       <= load_d;
            sethms_q     <= sethms_d;
            blank_mask_q <= blank_mask_d;
        end
    end

    assign set        = set_q;
    assign sethms     = sethms_q;
    assign hour_out   = hour_q;
    assign min_out    = min_q;
    assign sec_out    = sec_q;
    assign load       = load_q;
    assign blank_mask = blank_mask_q;

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Front-panel controller that sequences time-setting for the wall-clock datapath (clock counter, time-to-digit conversion, seven-segment displays).
- Debounces the four KEY buttons and runs a RUN/SET_HOUR/SET_MIN/SET_SEC mode machine.
- Holds edit copies of hour/min/sec, steps the selected field up or down with wrap and auto-repeat.
- Commits the new time with a one-cycle load, and produces the blink masks that gate the field enables of the display.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles a synchronized key must be stable before its debounced level changes.
- REPEAT_DELAY, 25000000: cycles up/down must be held before the first auto-repeat step.
- REPEAT_RATE, 5000000: cycles between subsequent auto-repeat steps.
- TIMEOUT_CYCLES, 500000000: cycles with no accepted key event before abandoning set mode.
- BLINK_HALF, 12500000: half-period of the blink phase, in cycles.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_n  in  4  raw active-low buttons: [0] mode, [1] up, [2] down, [3] cancel.
- hour_in  in  5  current hour from the clock counter, 0..23.
- min_in  in  6  current minute, 0..59.
- sec_in  in  6  current second, 0..59.
- set  out  1  1 while in any SET state; the clock counter holds while set=1.
- sethms  out  2  selected field: 0 none, 1 hour, 2 min, 3 sec.
- hour_out  out  5  edit hour.
- min_out  out  6  edit minute.
- sec_out  out  6  edit second.
- load  out  1  one-cycle pulse; clock counter copies hour_out/min_out/sec_out.
- blank_mask  out  3  {hour,min,sec}; 1 = blank that field this cycle.

Behaviour:
- Reset (async assert, sync release): state RUN, all outputs 0, edit registers 0, all counters 0, blink phase 0.
- Key path, per key:
  - 2-FF synchronizer, then a stability counter; the debounced level updates after DEBOUNCE_CYCLES consecutive equal samples.
  - press = one-cycle pulse on a debounced high-to-low transition.
  - held = debounced low.
- Auto-repeat (up/down only): while held in a SET state, a step pulse fires REPEAT_DELAY cycles after the press pulse, then every REPEAT_RATE cycles. Releasing the key clears the repeat counter.
- Event priority in one cycle: cancel > mode > up/down. Up and down both active in the same cycle are ignored.
- FSM, all outputs registered (effects visible the cycle after the press pulse):
  - RUN: on mode, capture hour_in/min_in/sec_in into the edit registers and go to SET_HOUR. Up/down/cancel are ignored.
  - SET_HOUR: mode goes to SET_MIN.
  - SET_MIN: mode goes to SET_SEC.
  - SET_SEC: mode goes to COMMIT.
  - COMMIT: load=1 for exactly one cycle, set stays 1 in that cycle, then RUN.
  - In any SET state, cancel or timeout goes to RUN with no load; the edit registers keep their values.
- Field arithmetic on an up/down press or step:
  - hour wraps 23 to 0 on up, 0 to 23 on down.
  - min and sec wrap 59 to 0 on up, 0 to 59 on down.
  - Only the selected field changes.
- Timeout counter: runs only in SET states and clears on any accepted press or step. Reaching TIMEOUT_CYCLES-1 forces RUN on the next cycle.
- Blink: the phase toggles every BLINK_HALF cycles, free-running. The blank_mask bit of the selected field equals the phase; the other bits are 0. In RUN, blank_mask=0.
- sethms: 1/2/3 in SET_HOUR/SET_MIN/SET_SEC, 3 in COMMIT, 0 in RUN.
- Reset mid-set: immediate return to RUN, load never pulses.

Decomposition:
- Package clock_ui_pkg:
  - state enum (RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT).
  - field enum matching the sethms encoding.
  - constants HOUR_MAX=23, MINSEC_MAX=59.
  - key index constants KEY_MODE/KEY_UP/KEY_DOWN/KEY_CANCEL.
- Sub-module key_debounce (sync + stability counter + press/held outputs), instantiated four times. Repeat logic stays in the top.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, TIMEOUT_CYCLES=200, BLINK_HALF=8):
- Bounce: key_n[0] toggles every 2 cycles for 10 cycles, then held low -> exactly one mode press; state SET_HOUR, set=1, sethms=1, hour_out=hour_in.
- Wrap: hour_in=23, enter SET_HOUR, press up once -> hour_out=0; press down -> hour_out=23. Advance to SET_MIN with min=0, press down -> min_out=59.
- Auto-repeat: in SET_SEC with sec=10, hold up for 50 cycles after the press -> sec_out=10+1+1+ (number of steps: first at 20, then 25,30,...,50) = 18. Release -> no further change.
- Commit: full mode sequence with edits 12:34:56 -> load high exactly one cycle with hour_out=12, min_out=34, sec_out=56; next cycle set=0, sethms=0.
- Cancel/timeout: cancel pressed with mode in the same cycle in SET_MIN -> RUN, no load. Separately, idle 200 cycles in SET_HOUR -> RUN, load never asserted.
- Blink and reset: in SET_MIN, blank_mask alternates 3'b010 / 3'b000 every 8 cycles. rst_n low mid-set -> all outputs 0 asynchronously.
